demux4_deserializer: RTL
========================

Name: demux4_deserializer

Overview:
- Downstream consumer of the 1-to-4 bit demux; takes the demux's 4-bit output plus the select value that drove it.
- Reassembles each channel's serial bit stream into WORD_W-bit words, with an independent partial-word accumulator per channel.
- Completed words from all four channels are merged onto one valid/ready output bus through a round-robin arbiter.
- Single-bit, one-hot-checked input side; word-wide, channel-tagged output side.

Parameters:
WORD_W, 8, bits per reassembled word (legal 2..16)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
bit_valid  input  1  demux output carries a bit this cycle
sel_in  input  2  select value driven to the demux this cycle (channel index)
demux_out  input  4  demux output bus
bit_ready  output  1  block accepts the bit this cycle
word_valid  output  1  output word present
word_ready  input  1  downstream accepts word
word_data  output  WORD_W  reassembled word, first-received bit in bit 0
word_chan  output  2  channel index of word_data
protocol_err  output  1  sticky: accepted beat had demux_out bits set outside sel_in

Behaviour:
- Beat accepted when bit_valid && bit_ready. Accepted bit = demux_out[sel_in].
- Per channel c: shift register sr[c] (WORD_W), counter cnt[c] (0..WORD_W-1), holding register hold[c] with flag hold_v[c].
- Accepted beat on channel c shifts LSB-first: sr[c] <= {bit, sr[c][WORD_W-1:1]}, cnt[c]++.
- Completing beat (cnt[c]==WORD_W-1): next cycle hold[c] = {bit, sr[c][WORD_W-1:1]} and hold_v[c]=1; cnt[c] returns to 0. Other channels unaffected.
- bit_ready = !(hold_v[sel_in] && cnt[sel_in]==WORD_W-1). It depends only on registered state and sel_in; a same-cycle pop of hold[sel_in] does not raise it.
- A completion into hold[c] and a pop of hold[c] can never coincide: completion requires hold_v[c]=0, and a pop requires hold_v[c]=1.
- Output stage is a registered word_valid/word_data/word_chan. It loads when !word_valid || word_ready.
- Load source is the first channel with hold_v set, searching rr_ptr, rr_ptr+1, ... mod 4.
- On load: clear that channel's hold_v, set rr_ptr = granted+1 mod 4. If no hold_v is set, word_valid goes 0 (after a handshake) or stays 0.
- While word_valid && !word_ready, word_data and word_chan are held stable.
- Latency: completing beat in cycle N -> hold_v at N+1 -> word_valid at N+2 (output stage free).
- Throughput: one word per cycle at the output; one bit per cycle at the input.
- protocol_err: set the cycle after an accepted beat where (demux_out & ~(4'b1 << sel_in)) != 0. The bit is still taken from demux_out[sel_in]. Cleared only by rst.
- Beats with bit_valid=0 are ignored entirely, including for the error check.
- Reset (synchronous, any time, including mid-word): all sr=0, cnt=0, hold=0, hold_v=0, word_valid=0, word_data=0, word_chan=0, rr_ptr=0, protocol_err=0. Partial words are discarded.
- bit_ready is 1 out of reset.

Test Plan:
- Single word: rst, then 8 beats on sel_in=2 with bits 1,0,1,0,0,1,0,1; word_ready=1 -> word_valid for exactly 1 cycle, 2 cycles after the last beat, word_data=0xA5, word_chan=2.
- Interleaved channels: alternate ch0/ch1 beats, ch0 carrying 0x3C and ch1 carrying 0xC3 -> word chan0=0x3C, then chan1=0xC3, next cycle; no cross-contamination.
- Backpressure on ch3, word_ready=0: send 0x11, 0x22, then 0x33 -> 0x11 sits in the output stage, 0x22 in hold[3]; bit_ready=0 while presenting the 8th bit of 0x33. Raise word_ready -> outputs 0x11, 0x22, 0x33 in order; no beat lost.
- Round-robin: word_ready=0, fill all channels (ch0 word first into the output stage, then ch1..ch3 holds plus a second ch0 word). Raise word_ready -> word_chan order 0,1,2,3,0.
- Protocol error: bit_valid=1, sel_in=1, demux_out=4'b0110 -> bit 1 accepted into ch1, protocol_err=1 next cycle and stays 1 until rst.
- Reset mid-word: 4 beats of 1 into ch0, rst 1 cycle, then 8 beats of 0 on ch0 -> word 0x00 on chan 0, no stale bits.

Source files
------------

// File: rtl/demux4_deserializer.sv
// Reassembles the four serial streams of a 1-to-4 bit demux into LSB-first words and
// merges the completed words onto one valid/ready bus through a round-robin arbiter.
module demux4_deserializer #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic [1:0]        sel_in,
  input  logic [3:0]        demux_out,
  output logic              bit_ready,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic [1:0]        word_chan,
  output logic              protocol_err
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:0] sr     [NCH];
  logic [WORD_W-1:0] hold   [NCH];
  logic [CNT_W-1:0]  cnt    [NCH];
  logic [NCH-1:0]    hold_v;
  logic [1:0]        rr_ptr;

  logic              in_bit;
  logic              accept;
  logic              beat_last;
  logic              stray;
  logic              load_en;
  logic [WORD_W-1:0] shifted;
  logic [1:0]        gnt;
  logic              gnt_found;
  logic [1:0]        idx;

  assign in_bit    = demux_out[sel_in];
  assign beat_last = (cnt[sel_in] == CNT_LAST);
  // A completing beat stalls only while the channel's holding register is still full.
  assign bit_ready = !(hold_v[sel_in] && beat_last);
  assign accept    = bit_valid && bit_ready;
  assign stray     = (demux_out & ~(4'b0001 << sel_in)) != 4'b0000;
  assign load_en   = !word_valid || word_ready;
  assign shifted   = {in_bit, sr[sel_in][WORD_W-1:1]};

  // Round-robin grant: nearest full holding register at or after rr_ptr.
  always_comb begin
    gnt       = rr_ptr;
    gnt_found = 1'b0;
    idx       = rr_ptr;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = rr_ptr + 2'(i);
      if (hold_v[idx]) begin
        gnt       = idx;
        gnt_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        sr[c]   <= '0;
        hold[c] <= '0;
        cnt[c]  <= '0;
      end
      hold_v       <= '0;
      rr_ptr       <= 2'd0;
      word_valid   <= 1'b0;
      word_data    <= '0;
      word_chan    <= 2'd0;
      protocol_err <= 1'b0;
    end else begin
      if (accept) begin
        sr[sel_in] <= shifted;
        if (beat_last) begin
          cnt[sel_in]    <= '0;
          hold[sel_in]   <= shifted;
          hold_v[sel_in] <= 1'b1;
        end else begin
          cnt[sel_in] <= cnt[sel_in] + CNT_W'(1);
        end
        if (stray) begin
          protocol_err <= 1'b1;
        end
      end
      // A completion and a pop never target the same channel in one cycle.
      if (load_en) begin
        word_valid <= gnt_found;
        if (gnt_found) begin
          word_data   <= hold[gnt];
          word_chan   <= gnt;
          hold_v[gnt] <= 1'b0;
          rr_ptr      <= gnt + 2'd1;
        end
      end
    end
  end

endmodule
